// File: rtl/seg_scan_capture.sv
// seg_scan_capture
//   Receiving end of a two-digit multiplexed 7-segment display. Watches the
//   shared segment bus and the two digit enables, rebuilds both hex digits
//   and emits one VALID pulse per complete scan frame.
//
//   Ports
//     CLK    : system clock, rising edge
//     RST_N  : asynchronous active-low reset
//     SEG    : segment bus {dp,g,f,e,d,c,b,a}, active high
//     D1, D2 : digit-1 / digit-2 enables, active high
//     DIG1   : decoded digit-1 nibble   (updated with VALID, held otherwise)
//     DIG2   : decoded digit-2 nibble   (updated with VALID, held otherwise)
//     DP     : captured decimal points {dp1,dp2}
//     VALID  : one-cycle pulse per complete frame
//     DECERR : at least one digit of the presented frame was undecodable
//     ERR    : one-cycle pulse on an enable protocol violation
//     STALL  : level, no enable transition for TIMEOUT-1 cycles
//
//   Parameters
//     SETTLE  : cycles enables and SEG must be stable before capture (1..255)
//     TIMEOUT : idle cycles before STALL asserts (2..65535)
//
//   Build option
//     SEG_SCAN_DP_EN : when defined, SEG[7] is captured per digit into DP;
//                      otherwise SEG[7] is ignored and DP stays 0.

module seg_scan_capture #(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] SEG,
  input  logic       D1,
  input  logic       D2,
  output logic [3:0] DIG1,
  output logic [3:0] DIG2,
  output logic [1:0] DP,
  output logic       VALID,
  output logic       DECERR,
  output logic       ERR,
  output logic       STALL
);

  typedef enum logic [1:0] {SYNC, PH1, PH2} state_t;
  typedef enum logic [1:0] {
    EN_GAP = 2'b00,
    EN_D2  = 2'b01,
    EN_D1  = 2'b10,
    EN_BAD = 2'b11
  } en_t;

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [15:0] STALL_AT    = 16'(TIMEOUT - 1);

  // Segment bus as seen by the capture logic; without the DP option the
  // dp bit is forced low so it takes part in neither settling nor capture.
  logic [7:0] seg_in;
`ifdef SEG_SCAN_DP_EN
  assign seg_in = SEG;
`else
  logic unused_dp;
  assign seg_in    = {1'b0, SEG[6:0]};
  assign unused_dp = SEG[7];
`endif

  state_t     state, state_nxt;
  en_t        r_en, p_en;
  logic [7:0] r_seg, p_seg;
  logic [7:0] cnt, cnt_nxt, cnt_run;
  logic       cap1, cap1_nxt, cap2, cap2_nxt;
  logic       take1, take2, fire_valid, fire_err;
  logic       same;
  logic [4:0] dec;
  logic [3:0] lat1, lat2;
  logic       bad1, bad2, ldp1, ldp2;
  logic [15:0] idle;

  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h3F:   r = 5'h00;
      7'h06:   r = 5'h01;
      7'h5B:   r = 5'h02;
      7'h4F:   r = 5'h03;
      7'h66:   r = 5'h04;
      7'h6D:   r = 5'h05;
      7'h7D:   r = 5'h06;
      7'h07:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h6F:   r = 5'h09;
      7'h77:   r = 5'h0A;
      7'h7C:   r = 5'h0B;
      7'h39:   r = 5'h0C;
      7'h5E:   r = 5'h0D;
      7'h79:   r = 5'h0E;
      7'h71:   r = 5'h0F;
      default: r = 5'h10;  // bad flag set, nibble 0
    endcase
    return r;
  endfunction

  assign dec  = seg_decode(r_seg[6:0]);
  assign same = (r_en == p_en) && (r_seg == p_seg);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cap1_nxt   = cap1;
    cap2_nxt   = cap2;
    take1      = 1'b0;
    take2      = 1'b0;
    fire_valid = 1'b0;
    fire_err   = 1'b0;
    cnt_run    = '0;
    if (same) cnt_run = (cnt == '1) ? cnt : cnt + 8'd1;

    if (r_en == EN_BAD) begin
      fire_err  = 1'b1;
      state_nxt = SYNC;
      cap1_nxt  = 1'b0;
      cap2_nxt  = 1'b0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        SYNC: begin
          cnt_nxt  = '0;
          cap1_nxt = 1'b0;
          cap2_nxt = 1'b0;
          if (r_en == EN_D1) state_nxt = PH1;
        end
        PH1: begin
          case (r_en)
            EN_D1: begin
              cnt_nxt = cnt_run;
              // Capture needs the current cycle stable as well, so the
              // latched value is one that has been held for SETTLE compares.
              if (!cap1 && same && cnt == SETTLE_LAST) begin
                take1    = 1'b1;
                cap1_nxt = 1'b1;
              end
            end
            EN_GAP: cnt_nxt = '0;
            EN_D2: begin
              cnt_nxt = '0;
              if (cap1) begin
                state_nxt = PH2;
              end else begin
                fire_err  = 1'b1;
                state_nxt = SYNC;
                cap1_nxt  = 1'b0;
                cap2_nxt  = 1'b0;
              end
            end
            default: ;
          endcase
        end
        PH2: begin
          case (r_en)
            EN_D2: begin
              cnt_nxt = cnt_run;
              if (!cap2 && same && cnt == SETTLE_LAST) begin
                take2    = 1'b1;
                cap2_nxt = 1'b1;
              end
            end
            EN_GAP: cnt_nxt = '0;
            EN_D1: begin
              cnt_nxt  = '0;
              cap1_nxt = 1'b0;
              cap2_nxt = 1'b0;
              if (cap2) begin
                fire_valid = 1'b1;
                state_nxt  = PH1;
              end else begin
                fire_err  = 1'b1;
                state_nxt = SYNC;
              end
            end
            default: ;
          endcase
        end
        default: state_nxt = SYNC;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= SYNC;
    else        state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_seg  <= '0;
      p_seg  <= '0;
      r_en   <= EN_GAP;
      p_en   <= EN_GAP;
      cnt    <= '0;
      cap1   <= 1'b0;
      cap2   <= 1'b0;
      lat1   <= '0;
      lat2   <= '0;
      bad1   <= 1'b0;
      bad2   <= 1'b0;
      ldp1   <= 1'b0;
      ldp2   <= 1'b0;
      idle   <= '0;
      DIG1   <= '0;
      DIG2   <= '0;
      DP     <= '0;
      DECERR <= 1'b0;
      VALID  <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      r_seg <= seg_in;
      r_en  <= en_t'({D1, D2});
      p_seg <= r_seg;
      p_en  <= r_en;
      cnt   <= cnt_nxt;
      cap1  <= cap1_nxt;
      cap2  <= cap2_nxt;
      if (take1) begin
        lat1 <= dec[3:0];
        bad1 <= dec[4];
        ldp1 <= r_seg[7];
      end
      if (take2) begin
        lat2 <= dec[3:0];
        bad2 <= dec[4];
        ldp2 <= r_seg[7];
      end
      VALID <= fire_valid;
      ERR   <= fire_err;
      if (fire_valid) begin
        DIG1   <= lat1;
        DIG2   <= lat2;
        DP     <= {ldp1, ldp2};
        DECERR <= bad1 | bad2;
      end
      if (r_en != p_en)    idle <= '0;
      else if (idle != '1) idle <= idle + 16'd1;
    end
  end

  assign STALL = (idle >= STALL_AT);

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receiving end of the two-digit multiplexed 7-segment display interface.
- Watches the shared segment bus and the two one-hot digit enables, then rebuilds both hex digits.
- Emits one VALID pulse per complete scan frame.
- Used as a readback/self-check monitor beside the display driver path, and as a bench-side decoder for ALU result displays.

Parameters:
- SETTLE, 4: consecutive cycles the enables and SEG must be unchanged before a digit is captured (legal range 1..255).
- TIMEOUT, 1024: cycles without an enable transition before STALL asserts (legal range 2..65535).

Ports:
- CLK, in, 1: system clock, rising edge.
- RST_N, in, 1: asynchronous active-low reset.
- SEG, in, 8: segment bus {dp,g,f,e,d,c,b,a}, active high.
- D1, in, 1: digit-1 enable, active high.
- D2, in, 1: digit-2 enable, active high.
- DIG1, out, 4: decoded digit-1 nibble.
- DIG2, out, 4: decoded digit-2 nibble.
- DP, out, 2: captured decimal points {dp1,dp2}.
- VALID, out, 1: one-cycle pulse; DIG1, DIG2, DP and DECERR are updated in the same cycle.
- DECERR, out, 1: at least one digit in the frame was undecodable; meaningful while VALID is high.
- ERR, out, 1: one-cycle pulse on a protocol violation.
- STALL, out, 1: level; the scan has stopped.

Behaviour:
- Reset: all outputs 0, FSM in SYNC, counters 0, capture flags cleared.
- Inputs are registered once (r_seg, r_en = {D1,D2}). All decisions use the registered values, so VALID and ERR appear 2 cycles after the causing input edge.
- Enable codes: 10 = digit 1, 01 = digit 2, 00 = blanking gap (legal), 11 = violation.
- FSM states: SYNC, PH1, PH2.
- SYNC:
  - Wait for r_en == 10, then go to PH1 with the settle counter cleared.
  - 01 and 00 are ignored.
  - 11 pulses ERR.
- PH1 (digit 1):
  - Settle counter increments while r_en and r_seg equal their previous-cycle values; any change clears it.
  - When the counter reaches SETTLE-1 and cap1 == 0: latch the decoded nibble and dp, set cap1. Capture happens only once per phase.
  - r_en == 00 holds state and clears the counter.
  - On r_en == 01: if cap1, go to PH2; else pulse ERR and go to SYNC.
- PH2 (digit 2):
  - Capture rules are the same as PH1, setting cap2.
  - On r_en == 10: if cap2, pulse VALID, present the latched pair, clear cap1/cap2 and go to PH1 with the counter cleared. The new digit-1 phase starts in this same cycle. If not cap2, pulse ERR and go to SYNC.
- r_en == 11 in any state: pulse ERR, clear cap flags, go to SYNC.
- Decode: SEG[6:0] maps to a hex nibble by the standard patterns:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Any other pattern (including blank 00) gives nibble 0 and sets that digit's bad flag.
  - DECERR = bad1 | bad2, updated with VALID.
- DIG1, DIG2, DP and DECERR hold between VALID pulses.
- Stall detection:
  - 16-bit idle counter clears on any change of r_en and saturates.
  - STALL = (idle counter >= TIMEOUT-1).
  - STALL clears the cycle after the next enable change.
  - The FSM is unaffected by STALL.
- RST_N low mid-frame: immediate clear; a partial frame never produces VALID.

Optional Feature:
- Macro: SEG_SCAN_DP_EN.
- Defined: SEG[7] is captured with each digit into DP.
- Undefined: SEG[7] is ignored and DP is constant 0. The port is still present, and decoding and the settle comparison use SEG[6:0] only.

Test Plan:
- Drive enables 10/01 alternating every 8 cycles, SEG=06 in digit 1 and 5B in digit 2 -> VALID pulses with DIG1=1, DIG2=2, DECERR=0, one pulse per period after the first full frame.
- Digit-1 phase of only 2 cycles with SETTLE=4 -> no capture; ERR pulse on 01 and FSM returns to SYNC, then recovers on the next clean frames.
- Force enables 11 for one cycle mid PH2 -> ERR pulse 2 cycles later, no VALID for that frame, caps cleared.
- SEG=00 in digit 2 -> VALID with DIG2=0, DECERR=1. With SEG_SCAN_DP_EN and SEG=86 in digit 1 -> DP=2'b10.
- Hold enables at 10 for TIMEOUT+5 cycles -> STALL high from idle count TIMEOUT-1, cleared after the switch to 01.
- Assert RST_N low during PH2 -> all outputs 0 immediately; the first VALID needs a full new frame.
